// File: rtl/instr_encoder.sv
// instr_encoder: turns decoded RV32I micro-op fields back into 32-bit
// instruction words and queues them in a small FIFO. Each word carries its
// byte address: BASE_ADDR for the first word, then +4 for each following word.
// Illegal field combinations complete the handshake but are never queued.
// They set a sticky err flag and bump a saturating counter instead.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       micro-op handshake
//   in_class                  0 R, 1 IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI,
//                             6 AUIPC, 7 JAL, 8 JALR (9-15 illegal)
//   in_alu_op                 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR,
//                             6 SRL, 7 SRA, 8 OR, 9 AND (10-15 illegal)
//   in_funct3                 width/condition for LOAD/STORE/BRANCH
//   in_rd, in_rs1, in_rs2     register indices
//   in_imm                    byte-offset immediate (shamt for shifts)
//   out_valid / out_ready     FIFO head handshake
//   out_instr, out_addr       encoded word at the head and its byte address
//   err, err_clr, err_cnt     sticky illegal flag, its clear, saturating count
module instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [3:0]        in_alu_op,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    input  logic              err_clr,
    output logic [7:0]        err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [3:0] CLS_R = 4'd0, CLS_IMM = 4'd1, CLS_LOAD = 4'd2,
                           CLS_STORE = 4'd3, CLS_BRANCH = 4'd4, CLS_LUI = 4'd5,
                           CLS_AUIPC = 4'd6, CLS_JAL = 4'd7, CLS_JALR = 4'd8;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
                           ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                           ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
                           ALU_AND = 4'd9;

    localparam logic [6:0] OPC_R = 7'b0110011, OPC_IMM = 7'b0010011,
                           OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                           OPC_BRANCH = 7'b1100011, OPC_LUI = 7'b0110111,
                           OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111;

    // Returns {legal, word}. The word is meaningless whenever legal is 0.
    function automatic logic [32:0] encode_f(
        input logic [3:0]  cls,
        input logic [3:0]  alu_op,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [2:0]  a_f3_s;
        logic [6:0]  a_f7_s;
        logic        a_ok_s;
        logic        a_shift_s;
        logic        ok_s;
        logic [31:0] w_s;
        logic        sx12_s;
        logic        sx13_s;
        logic        sx21_s;
        a_f3_s    = 3'b000;
        a_f7_s    = 7'b0000000;
        a_ok_s    = 1'b1;
        a_shift_s = 1'b0;
        sx12_s    = (imm[31:11] == {21{imm[11]}});
        sx13_s    = (imm[31:12] == {20{imm[12]}});
        sx21_s    = (imm[31:20] == {12{imm[20]}});
        case (alu_op)
            ALU_ADD:  a_f3_s = 3'b000;
            ALU_SUB:  begin a_f3_s = 3'b000; a_f7_s = 7'b0100000; end
            ALU_SLL:  begin a_f3_s = 3'b001; a_shift_s = 1'b1; end
            ALU_SLT:  a_f3_s = 3'b010;
            ALU_SLTU: a_f3_s = 3'b011;
            ALU_XOR:  a_f3_s = 3'b100;
            ALU_SRL:  begin a_f3_s = 3'b101; a_shift_s = 1'b1; end
            ALU_SRA:  begin a_f3_s = 3'b101; a_f7_s = 7'b0100000; a_shift_s = 1'b1; end
            ALU_OR:   a_f3_s = 3'b110;
            ALU_AND:  a_f3_s = 3'b111;
            default:  a_ok_s = 1'b0;
        endcase
        w_s  = 32'd0;
        ok_s = 1'b1;
        case (cls)
            CLS_R: begin
                w_s  = {a_f7_s, rs2, rs1, a_f3_s, rd, OPC_R};
                ok_s = a_ok_s;
            end
            CLS_IMM: begin
                // Shift immediates carry funct7 above a 5-bit shamt.
                if (a_shift_s) begin
                    w_s  = {a_f7_s, imm[4:0], rs1, a_f3_s, rd, OPC_IMM};
                    ok_s = a_ok_s && (imm[31:5] == 27'd0);
                end else begin
                    w_s  = {imm[11:0], rs1, a_f3_s, rd, OPC_IMM};
                    ok_s = a_ok_s && (alu_op != ALU_SUB) && sx12_s;
                end
            end
            CLS_LOAD: begin
                w_s  = {imm[11:0], rs1, f3, rd, OPC_LOAD};
                ok_s = sx12_s && (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            CLS_STORE: begin
                w_s  = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
                ok_s = sx12_s && (f3 <= 3'd2);
            end
            CLS_BRANCH: begin
                w_s  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
                ok_s = sx13_s && !imm[0] && (f3 != 3'd2) && (f3 != 3'd3);
            end
            CLS_LUI: begin
                w_s  = {imm[31:12], rd, OPC_LUI};
                ok_s = (imm[11:0] == 12'd0);
            end
            CLS_AUIPC: begin
                w_s  = {imm[31:12], rd, OPC_AUIPC};
                ok_s = (imm[11:0] == 12'd0);
            end
            CLS_JAL: begin
                w_s  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                ok_s = sx21_s && !imm[0];
            end
            CLS_JALR: begin
                w_s  = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
                ok_s = sx12_s;
            end
            default: ok_s = 1'b0;
        endcase
        return {ok_s, w_s};
    endfunction

    logic [31:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              out_valid_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic              err_r;
    logic [7:0]        err_cnt_r;
    logic [32:0]       enc_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              bad_s;

    // Encode the presented micro-op and classify the handshake.
    always_comb begin
        enc_s    = encode_f(in_class, in_alu_op, in_funct3, in_rd, in_rs1, in_rs2, in_imm);
        accept_s = in_valid && in_ready;
        push_s   = accept_s && enc_s[32];
        bad_s    = accept_s && !enc_s[32];
        pop_s    = out_valid_r && out_ready;
    end

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and head-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= enc_s[31:0];
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
        end
    end

    // Head byte address advances by one word per pop and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr_r <= BASE_ADDR;
        end else if (pop_s) begin
            out_addr_r <= out_addr_r + ADDR_W'(32'd4);
        end
    end

    // Sticky error flag (clear wins over set) and saturating illegal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r     <= 1'b0;
            err_cnt_r <= 8'd0;
        end else begin
            if (err_clr) begin
                err_r <= 1'b0;
            end else if (bad_s) begin
                err_r <= 1'b1;
            end
            if (bad_s && (err_cnt_r != 8'd255)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    // in_ready looks only at occupancy, never at a same-cycle pop.
    assign in_ready  = !rst && (count_r < DEPTH_C);
    assign out_valid = out_valid_r;
    assign out_instr = mem_r[rd_ptr_r];
    assign out_addr  = out_addr_r;
    assign err       = err_r;
    assign err_cnt   = err_cnt_r;

endmodule
